// File: rtl/lemon_mem_pkg.sv
// Shared types and constants for the core memory-port arbiter.
//   arb_state_t      : arbiter FSM encoding (IDLE, REQ, WAIT, RESP)
//   GNT_IFU/GNT_LSU  : grant identifiers
//   DEF_ADDR_W/DEF_DATA_W : default address/data widths
package lemon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant select between IFU and LSU.
// Configuration macro: MEM_ARB_RR_EN (round-robin; otherwise fixed LSU priority).
// Ports:
//   clk, rst_n   clock / async active-low reset (round-robin build only)
//   accept_i     a request was accepted this cycle (round-robin build only)
//   ifu_valid_i  IFU request valid
//   lsu_valid_i  LSU request valid
//   gnt_o        winning requester (GNT_IFU / GNT_LSU)
module mem_arb_grant
  import lemon_mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
`endif
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic gnt_o
);

`ifdef MEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = ptr_q;
    if (ifu_valid_i && !lsu_valid_i) gnt_o = GNT_IFU;
    else if (lsu_valid_i && !ifu_valid_i) gnt_o = GNT_LSU;
    ptr_d = ptr_q;
    // Pointer moves away from whoever was just served.
    if (accept_i) ptr_d = ~gnt_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= GNT_LSU;
    else        ptr_q <= ptr_d;
  end
`else
  // With no requester valid the grant value is irrelevant; default to LSU.
  always_comb begin
    gnt_o = (ifu_valid_i && !lsu_valid_i) ? GNT_IFU : GNT_LSU;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between IFU and LSU, one
// outstanding transaction at a time: accept -> issue -> wait -> respond.
// Configuration macro: MEM_ARB_RR_EN selects round-robin grant instead of
// fixed LSU-over-IFU priority.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   ifu_req_* / ifu_addr           IFU read request
//   ifu_resp_valid/_err            IFU response pulse / timeout flag
//   lsu_req_* / lsu_addr/wen/wdata/wmask  LSU request
//   lsu_resp_valid/_err            LSU response pulse / timeout flag
//   resp_data                      read data for the responding requester
//   mem_req_* / mem_addr/wen/wdata/wmask  downstream request (registered fields)
//   mem_resp_valid/_data           downstream response
module mem_port_arbiter
  import lemon_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                gnt, accept;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (accept),
`endif
    .ifu_valid_i(ifu_req_valid),
    .lsu_valid_i(lsu_req_valid),
    .gnt_o      (gnt)
  );

  assign ifu_req_ready = (state_q == IDLE) && (gnt == GNT_IFU) && ifu_req_valid;
  assign lsu_req_ready = (state_q == IDLE) && (gnt == GNT_LSU) && lsu_req_valid;
  assign accept        = ifu_req_ready || lsu_req_ready;

  assign mem_req_valid  = (state_q == REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = (state_q == RESP) && (gnt_q == GNT_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (gnt_q == GNT_LSU);
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_err   = lsu_resp_valid && err_q;
  assign resp_data      = rdata_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d = gnt;
          if (gnt == GNT_LSU) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : mem_resp_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= GNT_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
